// File: rtl/vga_fb_pkg.sv
`default_nettype none
// =============================================================================
// vga_fb_pkg : shared types and default geometry for the frame-buffer arbiter
// Rev 1.0
// =============================================================================
package vga_fb_pkg;

   typedef enum logic [0:0] {
      SYNC_WAIT = 1'b0,
      RUN       = 1'b1
   } state_t;

   localparam int HD_DEF      = 640;
   localparam int VD_DEF      = 480;
   localparam int SRC_W_DEF   = 320;
   localparam int MEM_LAT_DEF = 1;
   localparam int PIPE        = MEM_LAT_DEF + 2;

   // Extra address bit carrying the bank select when double buffering is built in
`ifdef DOUBLE_BUFFER_EN
   localparam int DB = 1;
`else
   localparam int DB = 0;
`endif

endpackage
`default_nettype wire

// File: rtl/vga_fb_arbiter_if.sv
`default_nettype none
// =============================================================================
// vga_fb_arbiter_if : timing-in, camera write, RAM and video-out bundle
// Rev 1.0
// =============================================================================
interface vga_fb_arbiter_if #(
   parameter int PIX_W  = 12,
   parameter int ADDR_W = 17,
   parameter int MA_W   = ADDR_W + vga_fb_pkg::DB
);
   logic              en;
   logic [11:0]       pixel_x;
   logic [11:0]       pixel_y;
   logic              video_on;
   logic              hsync_i;
   logic              vsync_i;

   logic              wr_valid;
   logic [ADDR_W-1:0] wr_addr;
   logic [PIX_W-1:0]  wr_data;
   logic              wr_ready;
   logic              wr_frame_done;

   logic              mem_en;
   logic              mem_we;
   logic [MA_W-1:0]   mem_addr;
   logic [PIX_W-1:0]  mem_wdata;
   logic [PIX_W-1:0]  mem_rdata;

   logic [PIX_W-1:0]  rgb;
   logic              hsync_o;
   logic              vsync_o;
   logic              de_o;
   logic [7:0]        frame_cnt;

   modport master (
      input  en, pixel_x, pixel_y, video_on, hsync_i, vsync_i,
      input  wr_valid, wr_addr, wr_data, wr_frame_done, mem_rdata,
      output wr_ready, mem_en, mem_we, mem_addr, mem_wdata,
      output rgb, hsync_o, vsync_o, de_o, frame_cnt
   );

   modport slave (
      output en, pixel_x, pixel_y, video_on, hsync_i, vsync_i,
      output wr_valid, wr_addr, wr_data, wr_frame_done, mem_rdata,
      input  wr_ready, mem_en, mem_we, mem_addr, mem_wdata,
      input  rgb, hsync_o, vsync_o, de_o, frame_cnt
   );
endinterface
`default_nettype wire

// File: rtl/vga_sync_delay.sv
`default_nettype none
// =============================================================================
// vga_sync_delay : N-stage shift register keeping sync/DE aligned with RGB
// Rev 1.0
// =============================================================================
module vga_sync_delay #(
   parameter int            N       = 3,
   parameter int            W       = 3,
   parameter logic [W-1:0]  RST_VAL = '0
) (
   input  wire logic         clk,
   input  wire logic         rst,
   input  wire logic [W-1:0] d,
   output logic      [W-1:0] q
);

   logic [N-1:0][W-1:0] r_stage;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) r_stage[i] <= RST_VAL;
      end else begin
         r_stage[0] <= d;
         for (int i = 1; i < N; i++) r_stage[i] <= r_stage[i-1];
      end
   end

   assign q = r_stage[N-1];

endmodule
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// =============================================================================
// vga_fb_arbiter : single-port frame-buffer sharing, camera writes vs 2x2 VGA reads
// Optional macro DOUBLE_BUFFER_EN : bank bit on mem_addr MSB, swapped at frame start
// Rev 1.0
// =============================================================================
module vga_fb_arbiter
   import vga_fb_pkg::*;
#(
   parameter int PIX_W   = 12,
   parameter int ADDR_W  = 17,
   parameter int SRC_W   = SRC_W_DEF,
   parameter int MEM_LAT = MEM_LAT_DEF,
   parameter int HD      = HD_DEF,
   parameter int VD      = VD_DEF
) (
   input  wire logic        clk,
   input  wire logic        rst,
   vga_fb_arbiter_if.master bus
);

   localparam int          DLY  = MEM_LAT + 2;
   localparam logic [11:0] HD_L = 12'(HD);
   localparam logic [11:0] VD_L = 12'(VD);

   state_t                  r_state;
   logic                    r_mem_en;
   logic                    r_mem_we;
   logic [ADDR_W+DB-1:0]    r_mem_addr;
   logic [PIX_W-1:0]        r_mem_wdata;
   logic [7:0]              r_frame_cnt;
   logic [MEM_LAT:0]        r_rd_tag;
   logic [PIX_W-1:0]        r_pixel_q;

   logic                    w_origin;
   logic                    w_start;
   logic                    w_active;
   logic                    w_rd_slot;
   logic [ADDR_W-1:0]       w_src_x;
   logic [ADDR_W-1:0]       w_src_y;
   logic [ADDR_W-1:0]       w_rd_addr;
   logic [ADDR_W+DB-1:0]    w_rd_addr_mem;
   logic [ADDR_W+DB-1:0]    w_wr_addr_mem;
   logic [2:0]              w_sync_q;

   assign w_src_x = ADDR_W'(bus.pixel_x[11:1]);
   assign w_src_y = ADDR_W'(bus.pixel_y[11:1]);

   if (SRC_W == 320) begin : g_addr_shift
      assign w_rd_addr = (w_src_y << 8) + (w_src_y << 6) + w_src_x;
   end else begin : g_addr_mul
      assign w_rd_addr = ADDR_W'(w_src_y * SRC_W) + w_src_x;
   end

   assign w_origin  = (bus.pixel_x == 12'd0) && (bus.pixel_y == 12'd0);
   assign w_start   = bus.en && w_origin;
   assign w_active  = bus.video_on && !bus.pixel_x[0] &&
                      (bus.pixel_x < HD_L) && (bus.pixel_y < VD_L);
   // The (0,0) read is issued in the same cycle that leaves SYNC_WAIT
   assign w_rd_slot = (r_state == RUN) ? w_active : w_start;

   assign bus.wr_ready = !w_rd_slot;

`ifdef DOUBLE_BUFFER_EN
   logic r_wr_bank;
   logic r_swap_pend;
   logic w_swap;
   logic w_bank;

   // The bank in force from the (0,0) cycle on, so the first read of a frame already sees it
   assign w_swap        = w_origin && r_swap_pend;
   assign w_bank        = r_wr_bank ^ w_swap;
   assign w_wr_addr_mem = {w_bank, bus.wr_addr};
   assign w_rd_addr_mem = {~w_bank, w_rd_addr};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_bank   <= 1'b0;
         r_swap_pend <= 1'b0;
      end else begin
         r_wr_bank   <= w_bank;
         r_swap_pend <= (r_swap_pend && !w_swap) || bus.wr_frame_done;
      end
   end
`else
   logic w_unused_frame_done;

   assign w_unused_frame_done = bus.wr_frame_done;
   assign w_wr_addr_mem       = bus.wr_addr;
   assign w_rd_addr_mem       = w_rd_addr;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= SYNC_WAIT;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_frame_cnt <= 8'd0;
         r_rd_tag    <= '0;
         r_pixel_q   <= '0;
      end else begin
         case (r_state)
            SYNC_WAIT: if (w_start) r_state <= RUN;
            RUN:       if (!bus.en) r_state <= SYNC_WAIT;
         endcase

         if (w_rd_slot) begin
            r_mem_en   <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= w_rd_addr_mem;
         end else if (bus.wr_valid) begin
            r_mem_en    <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= w_wr_addr_mem;
            r_mem_wdata <= bus.wr_data;
         end else begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
         end

         if (w_start) r_frame_cnt <= r_frame_cnt + 8'd1;

         // Leaving RUN discards reads still in flight
         if (r_state == RUN && !bus.en) r_rd_tag <= '0;
         else                           r_rd_tag <= {r_rd_tag[MEM_LAT-1:0], w_rd_slot};

         if (r_rd_tag[MEM_LAT] && r_state == RUN) r_pixel_q <= bus.mem_rdata;
      end
   end

   vga_sync_delay #(
      .N       (DLY),
      .W       (3),
      .RST_VAL (3'b110)
   ) u_sync_dly (
      .clk (clk),
      .rst (rst),
      .d   ({bus.hsync_i, bus.vsync_i, bus.video_on}),
      .q   (w_sync_q)
   );

   assign bus.hsync_o   = w_sync_q[2];
   assign bus.vsync_o   = w_sync_q[1];
   assign bus.de_o      = w_sync_q[0] && (r_state == RUN);
   assign bus.rgb       = bus.de_o ? r_pixel_q : '0;
   assign bus.mem_en    = r_mem_en;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// =============================================================================
// tb_vga_fb_arbiter : directed self-checking bench for vga_fb_arbiter
// Rev 1.0
// =============================================================================
module tb_vga_fb_arbiter;
   import vga_fb_pkg::*;

   localparam int PIX_W  = 12;
   localparam int ADDR_W = 17;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   vga_fb_arbiter_if #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) bus ();

   vga_fb_arbiter #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [PIX_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
      return a[11:0] ^ 12'hA5C;
   endfunction

   // Synchronous RAM, one cycle read latency
   always @(posedge clk) begin
      if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= ram_word(bus.mem_addr[ADDR_W-1:0]);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pix(input int x, input int y, input logic von);
      bus.pixel_x  = 12'(x);
      bus.pixel_y  = 12'(y);
      bus.video_on = von;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.en = 1'b0; bus.hsync_i = 1'b1; bus.vsync_i = 1'b1;
      bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_frame_done = 1'b0;
      set_pix(700, 500, 1'b0);
      tick(); tick();
      n_tests++; if (bus.hsync_o !== 1'b1 || bus.vsync_o !== 1'b1) begin n_fail++;
         $display("FAIL rst_syncs: got hs=%b vs=%b want 1 1", bus.hsync_o, bus.vsync_o); end
      n_tests++; if (bus.mem_en !== 1'b0 || bus.de_o !== 1'b0 || bus.rgb !== 12'h000 || bus.frame_cnt !== 8'd0) begin n_fail++;
         $display("FAIL rst_outs: got en=%b de=%b rgb=%h fc=%0d want 0 0 000 0", bus.mem_en, bus.de_o, bus.rgb, bus.frame_cnt); end
      // Run into a frame with sync low, then hit reset while a read is registered
      rst = 1'b0; bus.en = 1'b1; bus.hsync_i = 1'b0; bus.vsync_i = 1'b0;
      set_pix(640, 524, 1'b0);
      tick(); tick(); tick();
      set_pix(0, 0, 1'b1);
      tick();
      n_tests++; if (bus.mem_en !== 1'b1 || bus.hsync_o !== 1'b0) begin n_fail++;
         $display("FAIL pre_rst_active: got en=%b hs=%b want 1 0", bus.mem_en, bus.hsync_o); end
      #2 rst = 1'b1;
      #1;
      n_tests++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0 || bus.frame_cnt !== 8'd0) begin n_fail++;
         $display("FAIL async_rst_mem: got en=%b we=%b fc=%0d want 0 0 0", bus.mem_en, bus.mem_we, bus.frame_cnt); end
      n_tests++; if (bus.hsync_o !== 1'b1 || bus.vsync_o !== 1'b1 || bus.de_o !== 1'b0 || bus.rgb !== 12'h000) begin n_fail++;
         $display("FAIL async_rst_video: got hs=%b vs=%b de=%b rgb=%h want 1 1 0 000", bus.hsync_o, bus.vsync_o, bus.de_o, bus.rgb); end
      bus.hsync_i = 1'b1; bus.vsync_i = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_pix(2 + 2 * i, 1, 1'b1);
         tick();
         n_tests++; if (bus.mem_en !== 1'b0) begin n_fail++;
            $display("FAIL no_read_before_origin[%0d]: got mem_en=%b want 0", i, bus.mem_en); end
      end
   endtask

   task automatic test_read_path();
      set_pix(700, 524, 1'b0);
      tick(); tick(); tick();
      set_pix(0, 0, 1'b1);
      #1;
      n_tests++; if (bus.wr_ready !== 1'b0) begin n_fail++;
         $display("FAIL origin_wr_ready: got %b want 0", bus.wr_ready); end
      tick();
      n_tests++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr[ADDR_W-1:0] !== 17'd0) begin n_fail++;
         $display("FAIL rd_origin: got en=%b we=%b addr=%0d want 1 0 0", bus.mem_en, bus.mem_we, bus.mem_addr); end
      n_tests++; if (bus.frame_cnt !== 8'd1) begin n_fail++;
         $display("FAIL frame_cnt_first: got %0d want 1", bus.frame_cnt); end
      set_pix(1, 0, 1'b1);
      #1;
      n_tests++; if (bus.wr_ready !== 1'b1) begin n_fail++;
         $display("FAIL odd_wr_ready: got %b want 1", bus.wr_ready); end
      tick();
      n_tests++; if (bus.mem_en !== 1'b0 || bus.de_o !== 1'b0) begin n_fail++;
         $display("FAIL odd_idle: got en=%b de=%b want 0 0", bus.mem_en, bus.de_o); end
      set_pix(4, 3, 1'b1);
      tick();
      n_tests++; if (bus.mem_addr[ADDR_W-1:0] !== 17'd322 || bus.mem_we !== 1'b0 || bus.mem_en !== 1'b1) begin n_fail++;
         $display("FAIL rd_addr_4_3: got addr=%0d we=%b en=%b want 322 0 1", bus.mem_addr, bus.mem_we, bus.mem_en); end
      n_tests++; if (bus.de_o !== 1'b1 || bus.rgb !== 12'hA5C) begin n_fail++;
         $display("FAIL rgb_origin: got de=%b rgb=%h want 1 a5c", bus.de_o, bus.rgb); end
      set_pix(5, 3, 1'b1);
      tick();
      n_tests++; if (bus.de_o !== 1'b1 || bus.rgb !== 12'hA5C) begin n_fail++;
         $display("FAIL rgb_origin_repeat: got de=%b rgb=%h want 1 a5c", bus.de_o, bus.rgb); end
      set_pix(700, 3, 1'b0);
      tick();
      n_tests++; if (bus.de_o !== 1'b1 || bus.rgb !== 12'hB1E) begin n_fail++;
         $display("FAIL rgb_4_3: got de=%b rgb=%h want 1 b1e", bus.de_o, bus.rgb); end
      tick();
      n_tests++; if (bus.rgb !== 12'hB1E) begin n_fail++;
         $display("FAIL rgb_4_3_repeat: got %h want b1e", bus.rgb); end
      tick();
      n_tests++; if (bus.de_o !== 1'b0 || bus.rgb !== 12'h000) begin n_fail++;
         $display("FAIL rgb_blank: got de=%b rgb=%h want 0 000", bus.de_o, bus.rgb); end
   endtask

   task automatic test_write_line();
      int bad = 0;
      int first_bad = -1;
      int acc_cnt = 0;
      int k = 0;
      logic exp_acc;
      bus.wr_valid = 1'b1;
      for (int x = 0; x < 640; x++) begin
         set_pix(x, 10, 1'b1);
         bus.wr_addr = ADDR_W'(1000 + k);
         bus.wr_data = PIX_W'(k * 7);
         #1;
         exp_acc = x[0];
         if (bus.wr_ready !== exp_acc) begin bad++; if (first_bad < 0) first_bad = x; end
         if (bus.wr_ready === 1'b1) acc_cnt++;
         tick();
         if (exp_acc) begin
            if (!(bus.mem_en === 1'b1 && bus.mem_we === 1'b1 &&
                  bus.mem_addr[ADDR_W-1:0] === ADDR_W'(1000 + k) && bus.mem_wdata === PIX_W'(k * 7))) begin
               bad++; if (first_bad < 0) first_bad = x; end
            k++;
         end else if (!(bus.mem_en === 1'b1 && bus.mem_we === 1'b0 &&
                        bus.mem_addr[ADDR_W-1:0] === ADDR_W'(1600 + x / 2))) begin
            bad++; if (first_bad < 0) first_bad = x;
         end
      end
      bus.wr_valid = 1'b0;
      n_tests++; if (bad !== 0) begin n_fail++;
         $display("FAIL line_interleave: got %0d bad cycles (first x=%0d) want 0", bad, first_bad); end
      n_tests++; if (acc_cnt !== 320) begin n_fail++;
         $display("FAIL line_accept_count: got %0d want 320", acc_cnt); end
   endtask

   task automatic test_blanking();
      bus.wr_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         set_pix(640 + i, 10, 1'b0);
         bus.wr_addr = ADDR_W'(2000 + i);
         bus.wr_data = PIX_W'(12'h300 + i);
         #1;
         n_tests++; if (bus.wr_ready !== 1'b1) begin n_fail++;
            $display("FAIL blank_wr_ready[%0d]: got %b want 1", i, bus.wr_ready); end
         tick();
         n_tests++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr[ADDR_W-1:0] !== ADDR_W'(2000 + i) ||
                        bus.mem_wdata !== PIX_W'(12'h300 + i)) begin n_fail++;
            $display("FAIL blank_write[%0d]: got en=%b we=%b addr=%0d data=%h want 1 1 %0d %h",
                     i, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, 2000 + i, 12'h300 + i); end
      end
      bus.wr_valid = 1'b0;
      set_pix(648, 10, 1'b0);
      tick();
      n_tests++; if (bus.mem_en !== 1'b0 || bus.mem_addr[ADDR_W-1:0] !== 17'd2007 || bus.mem_wdata !== 12'h307) begin n_fail++;
         $display("FAIL idle_hold: got en=%b addr=%0d data=%h want 0 2007 307", bus.mem_en, bus.mem_addr, bus.mem_wdata); end
      // One-cycle hsync pulse must emerge after exactly three edges
      bus.hsync_i = 1'b0;
      tick();
      bus.hsync_i = 1'b1;
      tick();
      n_tests++; if (bus.hsync_o !== 1'b1) begin n_fail++;
         $display("FAIL hsync_early: got %b want 1", bus.hsync_o); end
      tick();
      n_tests++; if (bus.hsync_o !== 1'b0) begin n_fail++;
         $display("FAIL hsync_delay: got %b want 0", bus.hsync_o); end
      tick();
      n_tests++; if (bus.hsync_o !== 1'b1) begin n_fail++;
         $display("FAIL hsync_release: got %b want 1", bus.hsync_o); end
   endtask

   task automatic test_en_drop();
      set_pix(98, 50, 1'b1);
      tick();
      set_pix(99, 50, 1'b1);
      tick();
      set_pix(100, 50, 1'b1);
      bus.en = 1'b0;
      tick();
      n_tests++; if (bus.de_o !== 1'b0 || bus.rgb !== 12'h000) begin n_fail++;
         $display("FAIL drop_de: got de=%b rgb=%h want 0 000", bus.de_o, bus.rgb); end
      bus.en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_pix(102 + 2 * i, 50, 1'b1);
         #1;
         n_tests++; if (bus.wr_ready !== 1'b1) begin n_fail++;
            $display("FAIL wait_wr_ready[%0d]: got %b want 1", i, bus.wr_ready); end
         tick();
         n_tests++; if (bus.mem_en !== 1'b0 || bus.de_o !== 1'b0 || bus.rgb !== 12'h000) begin n_fail++;
            $display("FAIL wait_no_read[%0d]: got en=%b de=%b rgb=%h want 0 0 000", i, bus.mem_en, bus.de_o, bus.rgb); end
      end
      set_pix(0, 0, 1'b1);
      tick();
      n_tests++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr[ADDR_W-1:0] !== 17'd0) begin n_fail++;
         $display("FAIL resume_read: got en=%b we=%b addr=%0d want 1 0 0", bus.mem_en, bus.mem_we, bus.mem_addr); end
      n_tests++; if (bus.frame_cnt !== 8'd2) begin n_fail++;
         $display("FAIL resume_frame_cnt: got %0d want 2", bus.frame_cnt); end
      set_pix(700, 0, 1'b0);
      tick();
   endtask

   task automatic test_frame_wrap();
      for (int i = 0; i < 253; i++) begin
         set_pix(0, 0, 1'b1);
         tick();
      end
      n_tests++; if (bus.frame_cnt !== 8'd255) begin n_fail++;
         $display("FAIL frame_cnt_255: got %0d want 255", bus.frame_cnt); end
      tick();
      n_tests++; if (bus.frame_cnt !== 8'd0) begin n_fail++;
         $display("FAIL frame_cnt_wrap: got %0d want 0", bus.frame_cnt); end
      set_pix(700, 0, 1'b0);
      tick();
   endtask

`ifdef DOUBLE_BUFFER_EN
   task automatic test_double_buffer();
      set_pix(20, 200, 1'b1);
      tick();
      n_tests++; if (bus.mem_we !== 1'b0 || bus.mem_addr[ADDR_W] !== 1'b1) begin n_fail++;
         $display("FAIL db_read_bank0: got we=%b msb=%b want 0 1", bus.mem_we, bus.mem_addr[ADDR_W]); end
      set_pix(21, 200, 1'b1);
      bus.wr_valid = 1'b1; bus.wr_addr = 17'd5; bus.wr_frame_done = 1'b1;
      tick();
      bus.wr_valid = 1'b0; bus.wr_frame_done = 1'b0;
      n_tests++; if (bus.mem_we !== 1'b1 || bus.mem_addr[ADDR_W] !== 1'b0) begin n_fail++;
         $display("FAIL db_write_bank0: got we=%b msb=%b want 1 0", bus.mem_we, bus.mem_addr[ADDR_W]); end
      set_pix(22, 201, 1'b1);
      tick();
      n_tests++; if (bus.mem_addr[ADDR_W] !== 1'b1) begin n_fail++;
         $display("FAIL db_no_midframe_swap: got msb=%b want 1", bus.mem_addr[ADDR_W]); end
      set_pix(0, 0, 1'b1);
      tick();
      n_tests++; if (bus.mem_we !== 1'b0 || bus.mem_addr[ADDR_W] !== 1'b0) begin n_fail++;
         $display("FAIL db_read_swapped: got we=%b msb=%b want 0 0", bus.mem_we, bus.mem_addr[ADDR_W]); end
      set_pix(641, 0, 1'b0);
      bus.wr_valid = 1'b1; bus.wr_addr = 17'd9;
      tick();
      bus.wr_valid = 1'b0;
      n_tests++; if (bus.mem_we !== 1'b1 || bus.mem_addr[ADDR_W] !== 1'b1) begin n_fail++;
         $display("FAIL db_write_swapped: got we=%b msb=%b want 1 1", bus.mem_we, bus.mem_addr[ADDR_W]); end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_read_path();
      test_write_line();
      test_blanking();
      test_en_drop();
      test_frame_wrap();
`ifdef DOUBLE_BUFFER_EN
      test_double_buffer();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port frame-buffer RAM between two users: the camera write path and the VGA display read path.
- The camera side delivers QVGA 320x240 RGB444 pixels. The display side is the 640x480 VGA timing core, whose pixel_x/pixel_y/video_on/hsync/vsync drive this block.
- Each stored pixel is shown 2x2 (upscaled). Reads get every even active pixel cycle; all other cycles go to camera writes.
- Outputs RGB plus the timing signals, delayed so that they stay aligned with the RGB.

Parameters:
- PIX_W, 12, pixel width (RGB444)
- ADDR_W, 17, frame-buffer word address width (76800 words)
- SRC_W, 320, source image width in pixels
- MEM_LAT, 1, RAM read latency in cycles, counted from the edge at which the RAM samples its address
- HD, 640, active display width
- VD, 480, active display height

Ports:
- clk  in  1  pixel clock, 25 MHz
- rst  in  1  asynchronous reset, active-high
- en  in  1  enables display reads
- pixel_x  in  12  current horizontal count from the timing core
- pixel_y  in  12  current vertical count from the timing core
- video_on  in  1  active-region flag from the timing core
- hsync_i  in  1  horizontal sync from the timing core
- vsync_i  in  1  vertical sync from the timing core
- wr_valid  in  1  camera write request
- wr_addr  in  ADDR_W  camera write address
- wr_data  in  PIX_W  camera write data
- wr_ready  out  1  write accepted this cycle
- wr_frame_done  in  1  one-cycle pulse marking the last camera write of a frame
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W+DB  RAM address; DB = 1 with DOUBLE_BUFFER_EN, else 0
- mem_wdata  out  PIX_W  RAM write data
- mem_rdata  in  PIX_W  RAM read data
- rgb  out  PIX_W  display pixel
- hsync_o  out  1  delayed horizontal sync
- vsync_o  out  1  delayed vertical sync
- de_o  out  1  delayed data enable
- frame_cnt  out  8  count of displayed frames

Behaviour:
- Reset values: all outputs 0, except hsync_o = vsync_o = 1; state = SYNC_WAIT.
- State SYNC_WAIT:
  - No reads are issued; every cycle is a write slot.
  - Moves to RUN in the cycle where en = 1 and pixel_x = 0 and pixel_y = 0. The read for pixel (0,0) is issued in that same cycle.
- State RUN:
  - A read slot is any cycle with video_on = 1 and pixel_x[0] = 0.
  - Read address = (pixel_y >> 1) * SRC_W + (pixel_x >> 1), computed as (y << 8) + (y << 6) + x.
  - All other cycles are write slots.
  - en = 0 returns to SYNC_WAIT on the next edge. Any read already in flight completes, but its data is ignored.
- Write handshake:
  - wr_ready = 1 exactly in write slots; it is a combinational function of state and slot only, never of wr_valid.
  - A transfer occurs when wr_valid and wr_ready are both 1. Registered outputs on the next edge: mem_en = 1, mem_we = 1, mem_addr = wr_addr, mem_wdata = wr_data.
  - If a write is requested in a read slot, the read wins; wr_ready = 0 and the request is stalled, not dropped.
- Read: mem_en = 1, mem_we = 0, address as above, all registered.
- Idle slot (no read, no write): mem_en = 0; mem_addr and mem_wdata hold their previous values.
- Pipeline:
  - Read data is captured into pixel_q MEM_LAT+1 edges after the read was registered.
  - hsync_i, vsync_i and video_on are each delayed by PIPE = MEM_LAT+2 registers to give hsync_o, vsync_o, de_o.
  - rgb = pixel_q when de_o = 1, else 0.
  - In SYNC_WAIT, de_o is forced to 0; hsync_o and vsync_o keep passing through.
- frame_cnt increments, wrapping 255 -> 0, on each RUN entry into pixel (0,0). It does not increment in SYNC_WAIT.
- Wrap-around: pixel_x = 639 is odd, so it is a write slot. There is no read across a line boundary.

Optional Feature:
- Macro: DOUBLE_BUFFER_EN.
- When defined:
  - mem_addr MSB carries the bank bit. Writes use wr_bank; reads use the complementary bank.
  - A wr_frame_done pulse sets a pending flag.
  - At the cycle pixel_x = 0 and pixel_y = 0 with the flag set, wr_bank toggles and the flag clears. The swap therefore never happens mid-frame.
  - wr_bank resets to 0.
- When undefined:
  - Single bank; wr_frame_done is ignored.
  - mem_addr is ADDR_W bits wide.

Decomposition:
- Package vga_fb_pkg holds:
  - state enum {SYNC_WAIT, RUN}
  - the HD/VD/SRC_W defaults
  - PIPE
- One sub-module, vga_sync_delay: a parameterised N-stage shift register for hsync/vsync/de.

Test Plan:
1. Reset asserted mid-frame with mem_en = 1 -> all outputs go immediately to their reset values, hsync_o = vsync_o = 1; after release, no read occurs before pixel (0,0).
2. en = 1, pixel (0,0) reached -> mem_en = 1, we = 0, addr = 0 on the next edge. At pixel (4,3), addr = 1*320 + 2 = 322. rgb = that pixel's data exactly PIPE cycles later, aligned with de_o = 1.
3. wr_valid held constantly during an active line -> wr_ready toggles 0/1 with pixel_x[0]; exactly 320 writes are accepted per active line and none are lost.
4. During blanking (pixel_x >= 640), wr_valid = 1 -> wr_ready = 1 every cycle; mem_we = 1 with matching addr and data.
5. en dropped at pixel (100,50) -> SYNC_WAIT, de_o = 0, rgb = 0; en restored -> reads resume only at the next (0,0), and frame_cnt advances by exactly 1.
6. With DOUBLE_BUFFER_EN defined, wr_frame_done pulsed at line 200 -> the bank swaps only at the next (0,0); read MSB becomes 0 and write MSB becomes 1.
